// File: rtl/tone_pkg.sv
// Shared tone-generation definitions: widths, mute threshold and oscillator state.
// Used by the tone lookup, the oscillator and the sequencer.
package tone_pkg;

  localparam int unsigned PERIOD_W   = 32;
  localparam int unsigned VOL_W      = 8;
  localparam int unsigned MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } osc_state_t;

endpackage

// File: rtl/pwm_dac.sv
// Volume stage: a free-running counter compared against the level.
// The result is gated by the raw wave and registered onto the audio pin.
module pwm_dac #(
  parameter int unsigned VOL_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [VOL_W-1:0] level,
  output logic             audio_out
);

  logic [VOL_W-1:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt   <= '0;
      audio_out <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + 1'b1;
      audio_out <= en & (pwm_cnt < level);
    end
  end

endmodule

// File: rtl/tone_osc.sv
// Gated 50%-duty square-wave oscillator.
// Period changes and note-off are applied only at wave-period boundaries.
module tone_osc
  import tone_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                gate,
  input  logic [PERIOD_W-1:0] period,
  input  logic [VOL_W-1:0]    volume,
  output logic                wave,
  output logic                audio_out,
  output logic                cycle_start,
  output logic                busy
);

  osc_state_t          state;
  logic [PERIOD_W-1:0] phase;
  logic [PERIOD_W-1:0] cur_period;
  logic [PERIOD_W-1:0] phase_nxt;
  logic                wrap;
  logic                period_ok;

  assign phase_nxt = phase + PERIOD_W'(1);
  assign wrap      = (phase == cur_period - PERIOD_W'(1));
  assign period_ok = (period >= PERIOD_W'(MIN_PERIOD));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase       <= '0;
      cur_period  <= '0;
      wave        <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      cycle_start <= 1'b0;
      case (state)
        IDLE: begin
          phase <= '0;
          wave  <= 1'b0;
          if (gate && period_ok) begin
            state       <= RUN;
            cur_period  <= period;
            wave        <= 1'b1;
            cycle_start <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (wrap) begin
            phase <= '0;
            // A new cycle starts only from RUN with the gate still held
            if (state == RUN && gate && period_ok) begin
              cur_period  <= period;
              wave        <= 1'b1;
              cycle_start <= 1'b1;
            end else begin
              state <= IDLE;
              wave  <= 1'b0;
            end
          end else begin
            phase <= phase_nxt;
            wave  <= (phase_nxt < (cur_period >> 1));
            state <= gate ? RUN : DRAIN;
          end
        end
        default: begin
          state <= IDLE;
          phase <= '0;
          wave  <= 1'b0;
        end
      endcase
    end
  end

  pwm_dac #(
    .VOL_W(VOL_W)
  ) u_pwm (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (wave),
    .level    (volume),
    .audio_out(audio_out)
  );

endmodule
